// File: rtl/proc_pkg.sv
// Shared types and constants for simple_proc_core: opcode and FSM state
// encodings, instruction field positions and register-file size.
package proc_pkg;

  localparam int NREG    = 8;
  localparam int FIELD_W = 3;
  // Field positions counted down from the MSB of the instruction register:
  // III occupies [DATA_W-1 -: 3], XXX [DATA_W-4 -: 3], YYY [DATA_W-7 -: 3].
  localparam int OP_TOP  = 1;
  localparam int X_TOP   = 4;
  localparam int Y_TOP   = 7;

  typedef enum logic [2:0] {
    OP_MV   = 3'd0,
    OP_MVI  = 3'd1,
    OP_ADD  = 3'd2,
    OP_SUB  = 3'd3,
    OP_LD   = 3'd4,
    OP_ST   = 3'd5,
    OP_MVNZ = 3'd6,
    OP_AND  = 3'd7
  } opcode_e;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_T1   = 4'd4,
    S_T2   = 4'd5,
    S_T3   = 4'd6
  } state_e;

  // True for the three opcodes that go through the A/G ALU path.
  function automatic logic is_alu_op(input opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND);
  endfunction

endpackage

// File: rtl/simple_proc_core_if.sv
// Memory bus between simple_proc_core (master) and a single-port
// synchronous RAM/ROM (slave). With PROC_MEM_READY_EN defined the bus
// carries a mem_ready handshake from the memory.
interface simple_proc_core_if #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 5
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_dout;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_din;
`ifdef PROC_MEM_READY_EN
  logic              mem_ready;
`endif

  modport master (
    output mem_addr,
    output mem_dout,
    output mem_wr,
`ifdef PROC_MEM_READY_EN
    input  mem_ready,
`endif
    input  mem_din
  );

  modport slave (
    input  mem_addr,
    input  mem_dout,
    input  mem_wr,
`ifdef PROC_MEM_READY_EN
    output mem_ready,
`endif
    output mem_din
  );

endinterface

// File: rtl/proc_regfile.sv
// Eight general registers; R7 doubles as the program counter.
// One write port, a dedicated R7 increment port, two combinational reads.
module proc_regfile
  import proc_pkg::*;
#(
  parameter int DATA_W   = 9,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              we_i,
  input  logic [2:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              inc_i,
  input  logic [2:0]        raddr_a_i,
  input  logic [2:0]        raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o,
  output logic [DATA_W-1:0] pc_o
);

  logic [DATA_W-1:0] regs_q [NREG];

  // Register write / PC increment; the FSM never asserts both on R7 at once.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NREG - 1; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[NREG-1] <= DATA_W'(RESET_PC);
    end else begin
      if (we_i) begin
        regs_q[waddr_i] <= wdata_i;
      end
      if (inc_i) begin
        regs_q[NREG-1] <= regs_q[NREG-1] + {{(DATA_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];
  assign pc_o      = regs_q[NREG-1];

endmodule

// File: rtl/simple_proc_core.sv
// simple_proc_core: multi-cycle 8-register processor that fetches its own
// instructions through a synchronous memory port (R7 = PC).
// Optional feature macro: PROC_MEM_READY_EN (adds mem_ready wait states).
module simple_proc_core
  import proc_pkg::*;
#(
  parameter int DATA_W   = 9,
  parameter int ADDR_W   = 5,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  simple_proc_core_if.master bus,
  output logic              done,
  output logic [3:0]        state,
  output logic [DATA_W-1:0] pc
);

  state_e            state_q, state_d, after_s;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic              z_q, z_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              wr_q, wr_d;
  logic              last_s;
  logic              ready_s;

  opcode_e           op_s;
  logic [2:0]        x_s, y_s;
  logic [DATA_W-1:0] rx_s, ry_s, r7_s, alu_s;
  logic              rf_we_s, rf_inc_s;
  logic [DATA_W-1:0] rf_wdata_s;

`ifdef PROC_MEM_READY_EN
  assign ready_s = bus.mem_ready;
`else
  assign ready_s = 1'b1;
`endif

  assign op_s    = opcode_e'(ir_q[DATA_W-OP_TOP -: FIELD_W]);
  assign x_s     = ir_q[DATA_W-X_TOP -: FIELD_W];
  assign y_s     = ir_q[DATA_W-Y_TOP -: FIELD_W];
  // Where the FSM goes after the final cycle of an instruction.
  assign after_s = run ? S_F0 : S_IDLE;

  proc_regfile #(
    .DATA_W   (DATA_W),
    .RESET_PC (RESET_PC)
  ) u_rf (
    .clk       (clk),
    .resetn    (resetn),
    .we_i      (rf_we_s),
    .waddr_i   (x_s),
    .wdata_i   (rf_wdata_s),
    .inc_i     (rf_inc_s),
    .raddr_a_i (x_s),
    .raddr_b_i (y_s),
    .rdata_a_o (rx_s),
    .rdata_b_o (ry_s),
    .pc_o      (r7_s)
  );

  // ALU: modulo-2^DATA_W add, two's-complement subtract, bitwise AND.
  always_comb begin
    alu_s = a_q + ry_s;
    case (op_s)
      OP_ADD:  alu_s = a_q + ry_s;
      OP_SUB:  alu_s = a_q + ~ry_s + {{(DATA_W-1){1'b0}}, 1'b1};
      OP_AND:  alu_s = a_q & ry_s;
      default: alu_s = a_q + ry_s;
    endcase
  end

  // Next-state and datapath control for fetch and execute sequences.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    a_d        = a_q;
    g_d        = g_q;
    z_d        = z_q;
    addr_d     = addr_q;
    dout_d     = dout_q;
    wr_d       = 1'b0;
    rf_we_s    = 1'b0;
    rf_inc_s   = 1'b0;
    rf_wdata_s = ry_s;
    last_s     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_F0;
        else     state_d = S_IDLE;
      end
      S_F0: begin
        addr_d   = r7_s[ADDR_W-1:0];
        rf_inc_s = 1'b1;
        state_d  = S_F1;
      end
      S_F1: begin
        if (ready_s) state_d = S_F2;
        else         state_d = S_F1;
      end
      S_F2: begin
        ir_d    = bus.mem_din;
        state_d = S_T1;
      end
      S_T1: begin
        case (op_s)
          OP_MV: begin
            rf_we_s = 1'b1;
            last_s  = 1'b1;
            state_d = after_s;
          end
          OP_MVNZ: begin
            rf_we_s = ~z_q;
            last_s  = 1'b1;
            state_d = after_s;
          end
          OP_MVI: begin
            addr_d   = r7_s[ADDR_W-1:0];
            rf_inc_s = 1'b1;
            state_d  = S_T2;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            a_d     = rx_s;
            state_d = S_T2;
          end
          OP_LD: begin
            addr_d  = ry_s[ADDR_W-1:0];
            state_d = S_T2;
          end
          OP_ST: begin
            addr_d  = ry_s[ADDR_W-1:0];
            dout_d  = rx_s;
            wr_d    = 1'b1;
            state_d = S_T2;
          end
          default: state_d = S_IDLE;
        endcase
      end
      S_T2: begin
        if (is_alu_op(op_s)) begin
          g_d     = alu_s;
          z_d     = (alu_s == '0);
          state_d = S_T3;
        end else if (op_s == OP_ST) begin
          // Write strobe is held until the memory accepts it.
          if (ready_s) begin
            last_s  = 1'b1;
            state_d = after_s;
          end else begin
            wr_d    = 1'b1;
            state_d = S_T2;
          end
        end else begin
          // mvi / ld read wait
          if (ready_s) state_d = S_T3;
          else         state_d = S_T2;
        end
      end
      S_T3: begin
        rf_we_s = 1'b1;
        if ((op_s == OP_MVI) || (op_s == OP_LD)) rf_wdata_s = bus.mem_din;
        else                                     rf_wdata_s = g_q;
        last_s  = 1'b1;
        state_d = after_s;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      z_q     <= 1'b1;
      addr_q  <= '0;
      dout_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      g_q     <= g_d;
      z_q     <= z_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      wr_q    <= wr_d;
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.mem_dout = dout_q;
  assign bus.mem_wr   = wr_q;
  assign done         = last_s;
  assign state        = state_q;
  assign pc           = r7_s;

endmodule

// File: tb/tb_simple_proc_core.sv
// Self-checking bench for simple_proc_core: an instruction-level ISA model
// (registers, Z flag, memory image) predicts architectural state, fetch
// addresses, store traffic and instruction lengths.
module tb_simple_proc_core;
  import proc_pkg::*;

  localparam int DW    = 9;
  localparam int AW    = 5;
  localparam int MEMSZ = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          run;
  logic          done;
  logic [3:0]    state;
  logic [DW-1:0] pc;

  simple_proc_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  simple_proc_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0)) dut (
    .clk    (clk),
    .resetn (resetn),
    .run    (run),
    .bus    (bus),
    .done   (done),
    .state  (state),
    .pc     (pc)
  );

  always #5 clk = ~clk;

`ifdef PROC_MEM_READY_EN
  logic rdy = 1'b1;
  assign bus.mem_ready = rdy;
`endif

  // Bench RAM: synchronous single port, loadable from ld_img while ld_en.
  logic [DW-1:0] ram    [MEMSZ];
  logic [DW-1:0] ld_img [MEMSZ];
  logic          ld_en = 1'b0;
  always @(posedge clk) begin
    if (ld_en) begin
      for (int i = 0; i < MEMSZ; i++) ram[i] <= ld_img[i];
    end else if (bus.mem_wr) begin
      ram[bus.mem_addr] <= bus.mem_dout;
    end
    bus.mem_din <= ram[bus.mem_addr];
  end

  // Monitors: write strobes and instruction fetch addresses.
  int            wr_total = 0;
  logic [AW-1:0] wr_addr_last;
  logic [DW-1:0] wr_data_last;
  logic [AW-1:0] fetch_q [$];
  logic [3:0]    prev_st = 4'd0;
  always @(negedge clk) begin
    if (bus.mem_wr === 1'b1) begin
      wr_total++;
      wr_addr_last = bus.mem_addr;
      wr_data_last = bus.mem_dout;
    end
    if (state == S_F1 && prev_st != S_F1) fetch_q.push_back(bus.mem_addr);
    prev_st = state;
  end

  // ISA reference model.
  logic [DW-1:0] m_reg [8];
  logic          m_z;
  logic [DW-1:0] m_mem [MEMSZ];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [DW-1:0] enc(input int op, input int x, input int y);
    return DW'(op * 64 + x * 8 + y);
  endfunction

  task automatic model_exec(output int cyc, output bit wr, output logic [AW-1:0] fa,
                            output logic [AW-1:0] wa, output logic [DW-1:0] wd);
    logic [DW-1:0] ir, res, imm;
    int op, x, y;
    fa = m_reg[7][AW-1:0];
    ir = m_mem[fa];
    m_reg[7] = m_reg[7] + 1;
    op = int'(ir[8:6]); x = int'(ir[5:3]); y = int'(ir[2:0]);
    wr = 1'b0; wa = '0; wd = '0; cyc = 0;
    case (op)
      0: begin m_reg[x] = m_reg[y]; cyc = 4; end
      1: begin
        imm = m_mem[m_reg[7][AW-1:0]];
        m_reg[7] = m_reg[7] + 1;
        m_reg[x] = imm; cyc = 6;
      end
      2, 3, 7: begin
        if (op == 2)      res = m_reg[x] + m_reg[y];
        else if (op == 3) res = m_reg[x] - m_reg[y];
        else              res = m_reg[x] & m_reg[y];
        m_z = (res == 0); m_reg[x] = res; cyc = 6;
      end
      4: begin m_reg[x] = m_mem[m_reg[y][AW-1:0]]; cyc = 6; end
      5: begin
        wa = m_reg[y][AW-1:0]; wd = m_reg[x];
        m_mem[wa] = wd; wr = 1'b1; cyc = 5;
      end
      default: begin if (!m_z) m_reg[x] = m_reg[y]; cyc = 4; end
    endcase
  endtask

  // Apply reset with ld_img loaded into RAM and model; ends at a negedge.
  task automatic do_reset(input logic run_v);
    @(negedge clk);
    resetn = 1'b0; run = run_v; ld_en = 1'b1;
    repeat (2) @(negedge clk);
    ld_en = 1'b0; resetn = 1'b1;
    for (int i = 0; i < MEMSZ; i++) m_mem[i] = ld_img[i];
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_z = 1'b1;
    fetch_q.delete();
  endtask

  // Execute one instruction on DUT and model, then compare everything.
  task automatic step_check(input string tag, input bit drop_t2);
    int cyc_exp, n, wr0;
    bit wr_exp;
    logic [AW-1:0] fa_exp, wa_exp, fa_got;
    logic [DW-1:0] wd_exp;
    wr0 = wr_total;
    model_exec(cyc_exp, wr_exp, fa_exp, wa_exp, wd_exp);
    n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (drop_t2 && state == S_T2) run = 1'b0;
      if (done === 1'b1 || n >= 50) break;
    end
    n_cmp++;
    if (n != cyc_exp) begin
      n_bad++; $display("FAIL %s cycles: got %0d want %0d", tag, n, cyc_exp);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (fetch_q.size() == 0) begin
      n_bad++; $display("FAIL %s fetch: got none want %0d", tag, fa_exp);
    end else begin
      fa_got = fetch_q.pop_front();
      if (fa_got !== fa_exp) begin
        n_bad++; $display("FAIL %s fetch: got %0d want %0d", tag, fa_got, fa_exp);
      end
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dut.u_rf.regs_q[i] !== m_reg[i]) begin
        n_bad++; $display("FAIL %s R%0d: got %h want %h", tag, i, dut.u_rf.regs_q[i], m_reg[i]);
      end
    end
    n_cmp++;
    if (dut.z_q !== m_z) begin
      n_bad++; $display("FAIL %s Z: got %b want %b", tag, dut.z_q, m_z);
    end
    n_cmp++;
    if ((wr_total - wr0) != (wr_exp ? 1 : 0)) begin
      n_bad++; $display("FAIL %s wr_pulses: got %0d want %0d", tag, wr_total - wr0, wr_exp ? 1 : 0);
    end
    if (wr_exp) begin
      n_cmp++;
      if (wr_addr_last !== wa_exp || wr_data_last !== wd_exp || ram[wa_exp] !== wd_exp) begin
        n_bad++; $display("FAIL %s store: got %0d/%h ram %h want %0d/%h", tag, wr_addr_last,
                          wr_data_last, ram[wa_exp], wa_exp, wd_exp);
      end
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < MEMSZ; i++) ld_img[i] = '0;
  endtask

  task automatic test_reset();
    clear_img();
    do_reset(1'b1);
    @(negedge clk); resetn = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (state !== S_IDLE || pc !== '0 || bus.mem_addr !== '0 || bus.mem_dout !== '0 ||
        bus.mem_wr !== 1'b0 || done !== 1'b0 || dut.z_q !== 1'b1 || dut.ir_q !== '0) begin
      n_bad++; $display("FAIL reset_outputs: st %0d pc %h addr %h dout %h wr %b done %b z %b",
                        state, pc, bus.mem_addr, bus.mem_dout, bus.mem_wr, done, dut.z_q);
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dut.u_rf.regs_q[i] !== '0) begin
        n_bad++; $display("FAIL reset_R%0d: got %h want 0", i, dut.u_rf.regs_q[i]);
      end
    end
  endtask

  task automatic test_plan_program();
    clear_img();
    ld_img[0] = enc(1, 0, 0); ld_img[1] = 9'd5;
    ld_img[2] = enc(1, 1, 0); ld_img[3] = 9'd3;
    ld_img[4] = enc(2, 0, 1);
    ld_img[5] = enc(3, 0, 0);
    ld_img[6] = enc(6, 2, 1);
    ld_img[7] = enc(2, 0, 1);
    ld_img[8] = enc(6, 2, 1);
    ld_img[9] = enc(1, 3, 0);  ld_img[10] = 9'h1AB;
    ld_img[11] = enc(1, 4, 0); ld_img[12] = 9'd20;
    ld_img[13] = enc(5, 3, 4);
    ld_img[14] = enc(4, 5, 4);
    ld_img[15] = enc(1, 6, 0); ld_img[16] = 9'd2;
    ld_img[17] = enc(0, 7, 6);
    do_reset(1'b1);
    step_check("mvi_r0", 1'b0);
    step_check("mvi_r1", 1'b0);
    step_check("add_r0", 1'b0);
    n_cmp++;
    if (dut.u_rf.regs_q[0] !== 9'd8 || dut.z_q !== 1'b0 || pc !== 9'd5) begin
      n_bad++; $display("FAIL plan_add: R0 %h Z %b pc %h want 008 0 005", dut.u_rf.regs_q[0], dut.z_q, pc);
    end
    step_check("sub_r0", 1'b0);
    n_cmp++;
    if (dut.g_q !== 9'd0 || dut.z_q !== 1'b1) begin
      n_bad++; $display("FAIL plan_sub: G %h Z %b want 000 1", dut.g_q, dut.z_q);
    end
    step_check("mvnz_z1", 1'b0);
    n_cmp++;
    if (dut.u_rf.regs_q[2] !== 9'd0) begin
      n_bad++; $display("FAIL plan_mvnz_skip: R2 %h want 000", dut.u_rf.regs_q[2]);
    end
    step_check("add_nz", 1'b0);
    step_check("mvnz_z0", 1'b0);
    n_cmp++;
    if (dut.u_rf.regs_q[2] !== 9'd3) begin
      n_bad++; $display("FAIL plan_mvnz_take: R2 %h want 003", dut.u_rf.regs_q[2]);
    end
    step_check("mvi_r3", 1'b0);
    step_check("mvi_r4", 1'b0);
    step_check("st", 1'b0);
    n_cmp++;
    if (wr_addr_last !== 5'd20 || wr_data_last !== 9'h1AB) begin
      n_bad++; $display("FAIL plan_st: addr %0d data %h want 20 1ab", wr_addr_last, wr_data_last);
    end
    step_check("ld", 1'b0);
    n_cmp++;
    if (dut.u_rf.regs_q[5] !== 9'h1AB) begin
      n_bad++; $display("FAIL plan_ld: R5 %h want 1ab", dut.u_rf.regs_q[5]);
    end
    step_check("mvi_r6", 1'b0);
    step_check("mv_r7", 1'b0);
    n_cmp++;
    if (pc !== 9'd2) begin
      n_bad++; $display("FAIL plan_jump: pc %h want 002", pc);
    end
    step_check("after_jump", 1'b0);
    step_check("after_jump2", 1'b0);
  endtask

  task automatic test_run_drop();
    logic [DW-1:0] pc0;
    clear_img();
    ld_img[0] = enc(1, 0, 0); ld_img[1] = 9'd7;
    ld_img[2] = enc(1, 1, 0); ld_img[3] = 9'd9;
    ld_img[4] = enc(2, 0, 1);
    ld_img[5] = enc(7, 0, 1);
    do_reset(1'b1);
    step_check("drop_mvi0", 1'b0);
    step_check("drop_mvi1", 1'b0);
    step_check("drop_add", 1'b1);
    pc0 = pc;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (state !== S_IDLE || done !== 1'b0 || pc !== pc0) begin
        n_bad++; $display("FAIL idle_hold: st %0d done %b pc %h want 0 0 %h", state, done, pc, pc0);
      end
      @(negedge clk);
    end
    run = 1'b1;
    step_check("resume_and", 1'b0);
  endtask

  task automatic test_pc_wrap();
    clear_img();
    ld_img[0]  = enc(1, 7, 0); ld_img[1] = 9'd31;
    ld_img[31] = enc(2, 0, 0);
    do_reset(1'b1);
    step_check("wrap_jump", 1'b0);
    step_check("wrap_at31", 1'b0);
    n_cmp++;
    if (pc !== 9'd32) begin
      n_bad++; $display("FAIL wrap_pc: pc %h want 020", pc);
    end
    step_check("wrap_fetch0", 1'b0);
  endtask

  task automatic test_reset_mid_st();
    int wr0, n;
    clear_img();
    ld_img[0] = enc(1, 3, 0); ld_img[1] = 9'h055;
    ld_img[2] = enc(1, 4, 0); ld_img[3] = 9'd25;
    ld_img[4] = enc(5, 3, 4);
    do_reset(1'b1);
    step_check("mid_mvi3", 1'b0);
    step_check("mid_mvi4", 1'b0);
    wr0 = wr_total;
    n = 0;
    while (1) begin
      @(negedge clk); n++;
      if (state == S_T1 || n >= 20) break;
    end
    n_cmp++;
    if (state !== S_T1) begin
      n_bad++; $display("FAIL mid_reach_t1: st %0d want %0d", state, S_T1);
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.mem_wr !== 1'b0 || bus.mem_addr !== '0 || bus.mem_dout !== '0 || done !== 1'b0 ||
        state !== S_IDLE || pc !== '0 || dut.u_rf.regs_q[3] !== '0) begin
      n_bad++; $display("FAIL mid_reset_vals: wr %b addr %h dout %h done %b st %0d pc %h",
                        bus.mem_wr, bus.mem_addr, bus.mem_dout, done, state, pc);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (wr_total != wr0 || ram[25] !== '0) begin
      n_bad++; $display("FAIL mid_no_write: pulses %0d ram %h want 0 000", wr_total - wr0, ram[25]);
    end
    resetn = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < MEMSZ; i++) ld_img[i] = DW'($urandom_range(0, 511));
    do_reset(1'b1);
    for (int k = 0; k < 60; k++) step_check($sformatf("rand%0d", k), 1'b0);
  endtask

`ifdef PROC_MEM_READY_EN
  task automatic test_mem_ready();
    int n;
    clear_img();
    ld_img[0] = enc(1, 0, 0); ld_img[1] = 9'd5;
    do_reset(1'b1);
    n = 0;
    while (1) begin
      @(negedge clk); n++;
      if (state == S_F1 || n >= 20) break;
    end
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (state !== S_F1) begin
        n_bad++; $display("FAIL ready_hold%0d: st %0d want %0d", i, state, S_F1);
      end
    end
    rdy = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (dut.ir_q !== enc(1, 0, 0) || state !== S_T1) begin
      n_bad++; $display("FAIL ready_ir: ir %h st %0d want %h %0d", dut.ir_q, state, enc(1, 0, 0), S_T1);
    end
  endtask
`endif

  initial begin
    resetn = 1'b0;
    run    = 1'b0;
    test_reset();
    test_plan_program();
    test_run_drop();
    test_pc_wrap();
    test_reset_mid_st();
    test_random();
`ifdef PROC_MEM_READY_EN
    test_mem_ready();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
